// File: rtl/image_reorder_sequencer.sv
// image_reorder_sequencer
//
// Sequences a multi-image job: streams 256 pixels per image into an image
// buffer, kicks a hash engine once per image, then hands control to a
// reorder engine whose reference indices are written into an ordering table.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   start, num_images     job request (IDLE only) and image count N
//   pix_valid/pix_data    pixel stream in, pix_ready back-pressure out
//   buf_we/addr/wdata     image buffer write port (one pixel per pulse)
//   hash_start/hash_img   hash engine kick and image number, hash_done back
//   reorder_start         reorder engine kick; ref_valid/ref_index/reorder_done back
//   ord_we/addr/wdata     reordered-index table write port
//   busy, done            job active / single-cycle completion pulse
//   cur_image, error      image being processed / sticky protocol error
module image_reorder_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] num_images,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       buf_we,
  output logic [7:0] buf_addr,
  output logic [7:0] buf_wdata,
  output logic       hash_start,
  output logic [8:0] hash_img,
  input  logic       hash_done,
  output logic       reorder_start,
  input  logic       ref_valid,
  input  logic [8:0] ref_index,
  input  logic       reorder_done,
  output logic       ord_we,
  output logic [8:0] ord_addr,
  output logic [8:0] ord_wdata,
  output logic       busy,
  output logic       done,
  output logic [8:0] cur_image,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HSTART,
    HWAIT,
    REORDER,
    DONE
  } stateT;

  stateT      state_q;
  logic [8:0] numImg_q;
  logic [8:0] curImage_q;
  logic [7:0] pixCnt_q;
  logic [8:0] ordCnt_q;
  logic       pixReady_q;
  logic       bufWe_q;
  logic [7:0] bufAddr_q;
  logic [7:0] bufWdata_q;
  logic       hashStart_q;
  logic [8:0] hashImg_q;
  logic       reorderStart_q;
  logic       ordWe_q;
  logic [8:0] ordAddr_q;
  logic [8:0] ordWdata_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;

  logic [7:0] pixCnt_d;
  logic [8:0] ordCnt_d;
  logic [8:0] curImage_d;
  logic       transfer;
  logic       lastImage;

  // Incremented counters and handshake decode shared by the FSM below.
  // pix_ready is only ever high in LOAD, so a transfer implies LOAD.
  assign pixCnt_d   = pixCnt_q + 8'd1;
  assign ordCnt_d   = ordCnt_q + 9'd1;
  assign curImage_d = curImage_q + 9'd1;
  assign transfer   = pix_valid & pixReady_q;
  assign lastImage  = (curImage_q == (numImg_q - 9'd1));

  // Whole controller lives in one registered block so every output is a
  // flop. Pulse outputs default low each cycle and are raised only on the
  // edge that produces them; the pixel counter is 8 bits, so the 256th
  // transfer wraps it back to 0 ready for the next image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      numImg_q       <= '0;
      curImage_q     <= '0;
      pixCnt_q       <= '0;
      ordCnt_q       <= '0;
      pixReady_q     <= 1'b0;
      bufWe_q        <= 1'b0;
      bufAddr_q      <= '0;
      bufWdata_q     <= '0;
      hashStart_q    <= 1'b0;
      hashImg_q      <= '0;
      reorderStart_q <= 1'b0;
      ordWe_q        <= 1'b0;
      ordAddr_q      <= '0;
      ordWdata_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      bufWe_q        <= 1'b0;
      hashStart_q    <= 1'b0;
      reorderStart_q <= 1'b0;
      ordWe_q        <= 1'b0;
      done_q         <= 1'b0;

      // Reorder-engine activity is only legal while reordering.
      if ((ref_valid || reorder_done) && (state_q != REORDER)) begin
        error_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            numImg_q   <= num_images;
            curImage_q <= '0;
            pixCnt_q   <= '0;
            ordCnt_q   <= '0;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            if (num_images != 9'd0) begin
              state_q    <= LOAD;
              pixReady_q <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end

        LOAD: begin
          if (transfer) begin
            bufWe_q    <= 1'b1;
            bufAddr_q  <= pixCnt_q;
            bufWdata_q <= pix_data;
            pixCnt_q   <= pixCnt_d;
            if (pixCnt_q == 8'hFF) begin
              state_q    <= HSTART;
              pixReady_q <= 1'b0;
            end
          end
        end

        HSTART: begin
          hashStart_q <= 1'b1;
          hashImg_q   <= curImage_q;
          state_q     <= HWAIT;
        end

        HWAIT: begin
          if (hash_done) begin
            if (lastImage) begin
              // Image 0 is always the first reference, written on entry.
              state_q        <= REORDER;
              reorderStart_q <= 1'b1;
              ordWe_q        <= 1'b1;
              ordAddr_q      <= '0;
              ordWdata_q     <= '0;
              ordCnt_q       <= 9'd1;
            end else begin
              curImage_q <= curImage_d;
              state_q    <= LOAD;
              pixReady_q <= 1'b1;
            end
          end
        end

        REORDER: begin
          if (ref_valid) begin
            if (ordCnt_q < numImg_q) begin
              ordWe_q    <= 1'b1;
              ordAddr_q  <= ordCnt_q;
              ordWdata_q <= ref_index;
              ordCnt_q   <= ordCnt_d;
            end else begin
              error_q <= 1'b1;
            end
          end
          if (reorder_done) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          pixReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready     = pixReady_q;
  assign buf_we        = bufWe_q;
  assign buf_addr      = bufAddr_q;
  assign buf_wdata     = bufWdata_q;
  assign hash_start    = hashStart_q;
  assign hash_img      = hashImg_q;
  assign reorder_start = reorderStart_q;
  assign ord_we        = ordWe_q;
  assign ord_addr      = ordAddr_q;
  assign ord_wdata     = ordWdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cur_image     = curImage_q;
  assign error         = error_q;

endmodule

// File: tb/tb_image_reorder_sequencer.sv
// tb_image_reorder_sequencer
//
// Self-checking bench for image_reorder_sequencer. Reorder-phase behaviour
// is driven from a table of {inputs, expected outputs} rows; pixel loading,
// hashing handshakes, the empty job and the mid-job reset are hand-written
// sequences. Pixel k of every image carries data k.
module tb_image_reorder_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] num_images;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       buf_we;
  logic [7:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       hash_start;
  logic [8:0] hash_img;
  logic       hash_done;
  logic       reorder_start;
  logic       ref_valid;
  logic [8:0] ref_index;
  logic       reorder_done;
  logic       ord_we;
  logic [8:0] ord_addr;
  logic [8:0] ord_wdata;
  logic       busy;
  logic       done;
  logic [8:0] cur_image;
  logic       error;

  image_reorder_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_images(num_images),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .buf_we(buf_we),
    .buf_addr(buf_addr),
    .buf_wdata(buf_wdata),
    .hash_start(hash_start),
    .hash_img(hash_img),
    .hash_done(hash_done),
    .reorder_start(reorder_start),
    .ref_valid(ref_valid),
    .ref_index(ref_index),
    .reorder_done(reorder_done),
    .ord_we(ord_we),
    .ord_addr(ord_addr),
    .ord_wdata(ord_wdata),
    .busy(busy),
    .done(done),
    .cur_image(cur_image),
    .error(error)
  );

  typedef struct packed {
    logic       rv;
    logic [8:0] idx;
    logic       rd;
    logic       expWe;
    logic [8:0] expAddr;
    logic [8:0] expData;
    logic       expErr;
  } refVecT;

  refVecT     vecs [8];
  int         checkCount = 0;
  int         passCount  = 0;
  int         bufWrites  = 0;
  int         hashCount  = 0;
  int         ordWrites  = 0;
  logic [8:0] hashLog  [16];
  logic [8:0] ordTable [512];

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer on the falling edge: counts buffer writes, logs hash kicks and
  // captures the ordering table as the DUT writes it.
  always @(negedge clk) begin
    if (buf_we === 1'b1) bufWrites++;
    if (hash_start === 1'b1) begin
      hashLog[hashCount[3:0]] = hash_img;
      hashCount++;
    end
    if (ord_we === 1'b1) begin
      ordTable[ord_addr] = ord_wdata;
      ordWrites++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    else
      passCount++;
  endtask

  // Accept a job of n images on the next edge.
  task automatic applyStimulus(input logic [8:0] n);
    start = 1'b1;
    num_images = n;
    tick();
    start = 1'b0;
  endtask

  // Stream one 256-pixel image, optionally idling a cycle between pixels,
  // and check the buffer write after every transfer plus the hash kick
  // timing relative to the last transfer.
  task automatic loadImage(input int gap);
    int errs = 0;
    for (int k = 0; k < 256; k++) begin
      if (gap != 0 && k > 0) begin
        pix_valid = 1'b0;
        tick();
        if (buf_we !== 1'b0) errs++;
      end
      pix_valid = 1'b1;
      pix_data  = k[7:0];
      tick();
      if (buf_we !== 1'b1 || buf_addr !== k[7:0] || buf_wdata !== k[7:0]) errs++;
      if (k < 255 && pix_ready !== 1'b1) errs++;
    end
    pix_valid = 1'b0;
    checkOutput("pixel write errors", errs, 0);
    checkOutput("pix_ready after last pixel", pix_ready, 0);
    checkOutput("hash_start 1 cycle after last", hash_start, 0);
    tick();
    checkOutput("hash_start 2 cycles after last", hash_start, 1);
  endtask

  task automatic pulseHashDone();
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
  endtask

  // Apply reorder-phase table rows lo..hi, one cycle each.
  task automatic runRows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      ref_valid    = vecs[r].rv;
      ref_index    = vecs[r].idx;
      reorder_done = vecs[r].rd;
      tick();
      ref_valid    = 1'b0;
      reorder_done = 1'b0;
      checkOutput($sformatf("row%0d ord_we", r), ord_we, vecs[r].expWe);
      if (vecs[r].expWe) begin
        checkOutput($sformatf("row%0d ord_addr", r), ord_addr, vecs[r].expAddr);
        checkOutput($sformatf("row%0d ord_wdata", r), ord_wdata, vecs[r].expData);
      end
      checkOutput($sformatf("row%0d error", r), error, vecs[r].expErr);
      checkOutput($sformatf("row%0d reorder_start", r), reorder_start, 0);
      checkOutput($sformatf("row%0d done", r), done, 0);
    end
  endtask

  // Finish a job whose reorder_done has just been sampled: DONE, then the
  // done pulse with busy low, then quiet.
  task automatic finishJob();
    checkOutput("busy in DONE", busy, 1);
    tick();
    checkOutput("done pulse", done, 1);
    checkOutput("busy after done", busy, 0);
    tick();
    checkOutput("done single cycle", done, 0);
  endtask

  initial begin
    int baseBuf;
    int baseHash;
    int baseOrd;

    // N=4: refs 2,3 then 1 together with reorder_done.
    vecs[0] = '{1'b1, 9'd2, 1'b0, 1'b1, 9'd1, 9'd2, 1'b0};
    vecs[1] = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 9'd0, 1'b0};
    vecs[2] = '{1'b1, 9'd3, 1'b0, 1'b1, 9'd2, 9'd3, 1'b0};
    vecs[3] = '{1'b1, 9'd1, 1'b1, 1'b1, 9'd3, 9'd1, 1'b0};
    // N=2: one legal ref, two overflowing refs, then reorder_done.
    vecs[4] = '{1'b1, 9'd1, 1'b0, 1'b1, 9'd1, 9'd1, 1'b0};
    vecs[5] = '{1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 9'd0, 1'b1};
    vecs[6] = '{1'b1, 9'd7, 1'b0, 1'b0, 9'd0, 9'd0, 1'b1};
    vecs[7] = '{1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 9'd0, 1'b1};

    reset = 1'b0;
    start = 1'b0;
    num_images = '0;
    pix_valid = 1'b0;
    pix_data = '0;
    hash_done = 1'b0;
    ref_valid = 1'b0;
    ref_index = '0;
    reorder_done = 1'b0;
    for (int i = 0; i < 512; i++) ordTable[i] = '0;
    for (int i = 0; i < 16; i++) hashLog[i] = '0;

    repeat (2) tick();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset pix_ready", pix_ready, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset error", error, 0);
    checkOutput("reset cur_image", cur_image, 0);
    checkOutput("reset buf_we", buf_we, 0);
    checkOutput("reset ord_we", ord_we, 0);
    reset = 1'b1;

    // N=1, back-to-back pixels.
    $display("[TB] single image job");
    baseBuf = bufWrites;
    applyStimulus(9'd1);
    checkOutput("job1 busy", busy, 1);
    checkOutput("job1 pix_ready", pix_ready, 1);
    checkOutput("job1 cur_image", cur_image, 0);
    loadImage(0);
    checkOutput("job1 hash_img", hash_img, 0);
    pulseHashDone();
    checkOutput("job1 reorder_start", reorder_start, 1);
    checkOutput("job1 entry ord_we", ord_we, 1);
    checkOutput("job1 entry ord_addr", ord_addr, 0);
    checkOutput("job1 entry ord_wdata", ord_wdata, 0);
    checkOutput("job1 hash_start cleared", hash_start, 0);
    reorder_done = 1'b1;
    tick();
    reorder_done = 1'b0;
    checkOutput("job1 reorder_start single", reorder_start, 0);
    finishJob();
    checkOutput("job1 buf writes", bufWrites - baseBuf, 256);

    // N=3, one idle cycle between pixels; pix_valid poked during HWAIT.
    $display("[TB] three image job with gaps");
    baseBuf  = bufWrites;
    baseHash = hashCount;
    applyStimulus(9'd3);
    for (int i = 0; i < 3; i++) begin
      loadImage(1);
      checkOutput($sformatf("job2 hash_img %0d", i), hash_img, i);
      for (int w = 0; w < 3; w++) begin
        pix_valid = 1'b1;
        tick();
        checkOutput("job2 pix_ready in HWAIT", pix_ready, 0);
        checkOutput("job2 buf_we in HWAIT", buf_we, 0);
      end
      pix_valid = 1'b0;
      pulseHashDone();
      if (i < 2) begin
        checkOutput("job2 pix_ready next image", pix_ready, 1);
        checkOutput("job2 cur_image", cur_image, i + 1);
      end else begin
        checkOutput("job2 reorder_start", reorder_start, 1);
      end
    end
    reorder_done = 1'b1;
    tick();
    reorder_done = 1'b0;
    finishJob();
    checkOutput("job2 buf writes", bufWrites - baseBuf, 768);
    checkOutput("job2 hash count", hashCount - baseHash, 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("job2 hash log %0d", i), hashLog[baseHash + i], i);

    // N=4 reorder table.
    $display("[TB] four image reorder");
    baseOrd = ordWrites;
    applyStimulus(9'd4);
    for (int i = 0; i < 4; i++) begin
      loadImage(0);
      checkOutput("job3 hash_img", hash_img, i);
      pulseHashDone();
    end
    checkOutput("job3 reorder_start", reorder_start, 1);
    checkOutput("job3 entry ord_we", ord_we, 1);
    runRows(0, 3);
    finishJob();
    checkOutput("job3 ord[0]", ordTable[0], 0);
    checkOutput("job3 ord[1]", ordTable[1], 2);
    checkOutput("job3 ord[2]", ordTable[2], 3);
    checkOutput("job3 ord[3]", ordTable[3], 1);
    checkOutput("job3 ord writes", ordWrites - baseOrd, 4);
    checkOutput("job3 error", error, 0);

    // N=2 with too many references.
    $display("[TB] reference overflow");
    applyStimulus(9'd2);
    for (int i = 0; i < 2; i++) begin
      loadImage(0);
      pulseHashDone();
    end
    runRows(4, 7);
    finishJob();
    checkOutput("job4 error sticky", error, 1);

    // Empty job clears error and completes without writes.
    $display("[TB] empty job");
    baseBuf = bufWrites;
    baseOrd = ordWrites;
    applyStimulus(9'd0);
    checkOutput("job5 busy", busy, 1);
    checkOutput("job5 error cleared", error, 0);
    checkOutput("job5 done early", done, 0);
    tick();
    checkOutput("job5 done", done, 1);
    checkOutput("job5 busy after", busy, 0);
    tick();
    checkOutput("job5 buf writes", bufWrites - baseBuf, 0);
    checkOutput("job5 ord writes", ordWrites - baseOrd, 0);
    ref_valid = 1'b1;
    tick();
    ref_valid = 1'b0;
    checkOutput("idle ref_valid error", error, 1);
    checkOutput("idle ref_valid ord_we", ord_we, 0);

    // Reset asserted mid-load at pixel 100.
    $display("[TB] reset mid load");
    applyStimulus(9'd2);
    checkOutput("job6 error cleared", error, 0);
    for (int k = 0; k < 100; k++) begin
      pix_valid = 1'b1;
      pix_data  = k[7:0];
      tick();
    end
    pix_data = 8'd100;
    checkOutput("job6 pre-reset buf_addr", buf_addr, 99);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset buf_we", buf_we, 0);
    checkOutput("async reset buf_addr", buf_addr, 0);
    checkOutput("async reset pix_ready", pix_ready, 0);
    checkOutput("async reset busy", busy, 0);
    baseBuf  = bufWrites;
    baseHash = hashCount;
    baseOrd  = ordWrites;
    repeat (2) tick();
    reset = 1'b1;
    pix_valid = 1'b0;
    repeat (2) tick();
    checkOutput("post-reset buf writes", bufWrites - baseBuf, 0);
    checkOutput("post-reset hash count", hashCount - baseHash, 0);
    checkOutput("post-reset ord writes", ordWrites - baseOrd, 0);
    applyStimulus(9'd1);
    checkOutput("job7 busy", busy, 1);
    checkOutput("job7 cur_image", cur_image, 0);
    loadImage(0);
    checkOutput("job7 hash_img", hash_img, 0);
    pulseHashDone();
    checkOutput("job7 reorder_start", reorder_start, 1);
    reorder_done = 1'b1;
    tick();
    reorder_done = 1'b0;
    finishJob();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
